controle_multiciclo: RTL and testbench

Multicycle main control FSM for the MIPS datapath. Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and write-back steps. Drives every datapath enable and mux select, and generates the 2-bit `ula_opcode` consumed by `controle_ula`. It also consumes the `controle_jr` flag that `controle_ula` returns, which implements `jr`.

---
 rtl/controle_multiciclo.sv | 191 +++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle main control FSM for the MIPS datapath.
// Decodes the instruction opcode and steps through fetch, decode, execute,
// memory and write-back, driving every datapath enable and mux select.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   opcode[5:0]           instruction bits [31:26] from the IR
//   controle_jr           jr flag from controle_ula (used only in R_EXEC)
//   ula_opcode[1:0]       ALU class: 00 add, 01 sub, 10 funct
//   pc_escreve            unconditional PC write
//   pc_escreve_cond       PC write qualified by ALU zero
//   iord                  memory address select (0 PC, 1 ALUOut)
//   mem_le, mem_escreve   memory read / write strobes
//   ir_escreve            IR load
//   reg_dst               destination (0 rt, 1 rd)
//   mem_para_reg          write-back source (0 ALUOut, 1 MDR)
//   reg_escreve           register file write
//   ula_fonte_a           ALU A (0 PC, 1 A)
//   ula_fonte_b[1:0]      ALU B (00 B, 01 4, 10 imm, 11 imm<<2)
//   fonte_pc[1:0]         PC source (00 ALU, 01 ALUOut, 10 jump, 11 A)
//   opcode_invalido       one-cycle pulse on an unsupported opcode in DECODE
//   estado[3:0]           current state code (debug)
//
// Configuration macro: CONTROLE_ADDI_EN builds the addi states (11, 12);
// without it opcode 001000 is reported as invalid.
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       controle_jr,
  output logic [1:0] ula_opcode,
  output logic       pc_escreve,
  output logic       pc_escreve_cond,
  output logic       iord,
  output logic       mem_le,
  output logic       mem_escreve,
  output logic       ir_escreve,
  output logic       reg_dst,
  output logic       mem_para_reg,
  output logic       reg_escreve,
  output logic       ula_fonte_a,
  output logic [1:0] ula_fonte_b,
  output logic [1:0] fonte_pc,
  output logic       opcode_invalido,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    INICIO    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BEQ       = 4'd9,
    JUMP      = 4'd10
`ifdef CONTROLE_ADDI_EN
    ,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CONTROLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  state_t state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= INICIO;
    else       state_q <= state_d;
  end

  assign estado = state_q;

  always_comb begin
    state_d         = INICIO;
    ula_opcode      = 2'b00;
    pc_escreve      = 1'b0;
    pc_escreve_cond = 1'b0;
    iord            = 1'b0;
    mem_le          = 1'b0;
    mem_escreve     = 1'b0;
    ir_escreve      = 1'b0;
    reg_dst         = 1'b0;
    mem_para_reg    = 1'b0;
    reg_escreve     = 1'b0;
    ula_fonte_a     = 1'b0;
    ula_fonte_b     = 2'b00;
    fonte_pc        = 2'b00;
    opcode_invalido = 1'b0;

    case (state_q)
      INICIO: state_d = FETCH;
      FETCH: begin
        mem_le      = 1'b1;
        ir_escreve  = 1'b1;
        pc_escreve  = 1'b1;
        ula_fonte_b = 2'b01;
        state_d     = DECODE;
      end
      DECODE: begin
        ula_fonte_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = R_EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_J:         state_d = JUMP;
`ifdef CONTROLE_ADDI_EN
          OP_ADDI:      state_d = ADDI_EXEC;
`endif
          default: begin
            opcode_invalido = 1'b1;
            state_d         = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ula_fonte_a = 1'b1;
        ula_fonte_b = 2'b10;
        state_d     = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_le  = 1'b1;
        iord    = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_escreve  = 1'b1;
        mem_para_reg = 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        mem_escreve = 1'b1;
        iord        = 1'b1;
        state_d     = FETCH;
      end
      R_EXEC: begin
        ula_fonte_a = 1'b1;
        ula_opcode  = 2'b10;
        // jr completes here: PC loads from A and write-back is skipped
        if (controle_jr) begin
          pc_escreve = 1'b1;
          fonte_pc   = 2'b11;
          state_d    = FETCH;
        end else begin
          state_d    = R_WB;
        end
      end
      R_WB: begin
        reg_dst     = 1'b1;
        reg_escreve = 1'b1;
        state_d     = FETCH;
      end
      BEQ: begin
        ula_fonte_a     = 1'b1;
        ula_opcode      = 2'b01;
        pc_escreve_cond = 1'b1;
        fonte_pc        = 2'b01;
        state_d         = FETCH;
      end
      JUMP: begin
        pc_escreve = 1'b1;
        fonte_pc   = 2'b10;
        state_d    = FETCH;
      end
`ifdef CONTROLE_ADDI_EN
      ADDI_EXEC: begin
        ula_fonte_a = 1'b1;
        ula_fonte_b = 2'b10;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        reg_escreve = 1'b1;
        state_d     = FETCH;
      end
`endif
      default: state_d = INICIO;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Testbench for controle_multiciclo: directed instructions and resets,
// then randomized instruction streams, checked cycle by cycle against a
// per-instruction state-sequence model and a per-state output table.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       controle_jr;
  logic [1:0] ula_opcode;
  logic       pc_escreve, pc_escreve_cond, iord, mem_le, mem_escreve;
  logic       ir_escreve, reg_dst, mem_para_reg, reg_escreve, ula_fonte_a;
  logic [1:0] ula_fonte_b, fonte_pc;
  logic       opcode_invalido;
  logic [3:0] estado;

  int errors = 0;
  int checks = 0;

`ifdef CONTROLE_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] ula_op;
    logic       pcw, pcwc, iord, mle, mes, irw, rdst, m2r, rw, fa;
    logic [1:0] fb, fpc;
    logic       inv;
  } ctl_t;

  ctl_t obs;
  assign obs = {ula_opcode, pc_escreve, pc_escreve_cond, iord, mem_le,
                mem_escreve, ir_escreve, reg_dst, mem_para_reg, reg_escreve,
                ula_fonte_a, ula_fonte_b, fonte_pc, opcode_invalido};

  controle_multiciclo dut (
    .clock(clock), .reset(reset), .opcode(opcode), .controle_jr(controle_jr),
    .ula_opcode(ula_opcode), .pc_escreve(pc_escreve),
    .pc_escreve_cond(pc_escreve_cond), .iord(iord), .mem_le(mem_le),
    .mem_escreve(mem_escreve), .ir_escreve(ir_escreve), .reg_dst(reg_dst),
    .mem_para_reg(mem_para_reg), .reg_escreve(reg_escreve),
    .ula_fonte_a(ula_fonte_a), .ula_fonte_b(ula_fonte_b),
    .fonte_pc(fonte_pc), .opcode_invalido(opcode_invalido), .estado(estado)
  );

  always #5 clock = ~clock;

  function automatic bit supported(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b000010 || (ADDI_EN && op == 6'b001000);
  endfunction

  // Expected datapath controls for a given state, opcode and jr flag.
  function automatic ctl_t exp_ctl(int s, logic [5:0] op, logic jr);
    ctl_t c = '0;
    case (s)
      1:  begin c.mle = 1; c.irw = 1; c.pcw = 1; c.fb = 2'b01; end
      2:  begin c.fb = 2'b11; c.inv = !supported(op); end
      3:  begin c.fa = 1; c.fb = 2'b10; end
      4:  begin c.mle = 1; c.iord = 1; end
      5:  begin c.rw = 1; c.m2r = 1; end
      6:  begin c.mes = 1; c.iord = 1; end
      7:  begin c.fa = 1; c.ula_op = 2'b10;
                if (jr) begin c.pcw = 1; c.fpc = 2'b11; end end
      8:  begin c.rdst = 1; c.rw = 1; end
      9:  begin c.fa = 1; c.ula_op = 2'b01; c.pcwc = 1; c.fpc = 2'b01; end
      10: begin c.pcw = 1; c.fpc = 2'b10; end
      11: begin c.fa = 1; c.fb = 2'b10; end
      12: begin c.rw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  int exp_seq[$];

  // Expected state walk of one instruction, starting at FETCH.
  task automatic build_seq(input logic [5:0] op, input logic jr);
    exp_seq = '{1, 2};
    if (op == 6'b100011)                 exp_seq = '{1, 2, 3, 4, 5};
    else if (op == 6'b101011)            exp_seq = '{1, 2, 3, 6};
    else if (op == 6'b000000)            exp_seq = jr ? '{1, 2, 7} : '{1, 2, 7, 8};
    else if (op == 6'b000100)            exp_seq = '{1, 2, 9};
    else if (op == 6'b000010)            exp_seq = '{1, 2, 10};
    else if (ADDI_EN && op == 6'b001000) exp_seq = '{1, 2, 11, 12};
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_cycle(input int s, input logic [5:0] op, input logic jr);
    chk("estado", 32'(estado), 32'(s));
    chk($sformatf("ctl_s%0d_op%b", s, op), 32'(obs), 32'(exp_ctl(s, op, jr)));
    chk("mem_rd_wr_excl", 32'(mem_le & mem_escreve), 32'd0);
    if (s != 1) chk("rw_pcw_excl", 32'(reg_escreve & pc_escreve), 32'd0);
  endtask

  // Runs the first n states of an instruction (n<0: all), from FETCH at posedge+1.
  task automatic run_instr(input logic [5:0] op, input logic jr, input int n);
    int len;
    opcode = op;
    build_seq(op, jr);
    len = (n < 0 || n > exp_seq.size()) ? exp_seq.size() : n;
    for (int i = 0; i < len; i++) begin
      controle_jr = (exp_seq[i] == 7) ? jr : 1'($urandom);
      @(negedge clock);
      check_cycle(exp_seq[i], op, jr);
      if (i != len - 1 || n < 0) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  // Asserts reset mid-cycle (no edge), checks, then releases into FETCH.
  task automatic async_reset_abort;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_estado", 32'(estado), 32'd0);
    chk("rst_async_ctl", 32'(obs), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  logic [5:0] op_r;
  logic       jr_r;

  initial begin
    reset = 1'b1;
    opcode = 6'b000000;
    controle_jr = 1'b0;
    #2;
    chk("reset_estado", 32'(estado), 32'd0);
    chk("reset_ctl", 32'(obs), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_held_estado", 32'(estado), 32'd0);
    chk("reset_held_ctl", 32'(obs), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed instructions
    run_instr(6'b100011, 1'b0, -1);   // lw
    run_instr(6'b000000, 1'b0, -1);   // R-type
    run_instr(6'b000000, 1'b1, -1);   // jr
    run_instr(6'b000100, 1'b0, -1);   // beq
    run_instr(6'b000010, 1'b0, -1);   // j
    run_instr(6'b111111, 1'b0, -1);   // invalid
    run_instr(6'b001000, 1'b0, -1);   // addi (invalid unless built in)
    run_instr(6'b101011, 1'b0, -1);   // sw

    // Reset mid-MEM_READ and mid-MEM_WRITE
    run_instr(6'b100011, 1'b0, 4);
    async_reset_abort();
    run_instr(6'b101011, 1'b0, 4);
    async_reset_abort();
    run_instr(6'b100011, 1'b0, -1);

    // Randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0: op_r = 6'b100011;
        1: op_r = 6'b101011;
        2: op_r = 6'b000000;
        3: op_r = 6'b000100;
        4: op_r = 6'b000010;
        5: op_r = 6'b001000;
        6: op_r = 6'b111111;
        default: op_r = 6'($urandom);
      endcase
      jr_r = 1'($urandom);
      run_instr(op_r, jr_r, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
